// File: rtl/calc_op_sequencer_if.sv
// Command, response and adder-drive channels of the calculator op sequencer.
// The slave side is the sequencer; the master side is the core and the adder.
interface calc_op_sequencer_if #(
   parameter int WIDTH     = 16,
   parameter int RES_WIDTH = 32
);
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [3:0]           cmd_op;
   logic [WIDTH-1:0]     cmd_p;
   logic [WIDTH-1:0]     cmd_q;

   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [RES_WIDTH-1:0] rsp_result;
   logic                 rsp_carry;
   logic                 rsp_overflow;
   logic                 rsp_error;

   logic [WIDTH-1:0]     add_p;
   logic [WIDTH-1:0]     add_q;
   logic [3:0]           add_cmd;
   logic [RES_WIDTH-1:0] add_sum;
   logic                 add_c;
   logic                 add_o;

   modport master (
      output cmd_valid, cmd_op, cmd_p, cmd_q,
      input  cmd_ready,
      input  rsp_valid, rsp_result, rsp_carry,
      input  rsp_overflow, rsp_error,
      output rsp_ready,
      input  add_p, add_q, add_cmd,
      output add_sum, add_c, add_o
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_p, cmd_q,
      output cmd_ready,
      output rsp_valid, rsp_result, rsp_carry,
      output rsp_overflow, rsp_error,
      input  rsp_ready,
      output add_p, add_q, add_cmd,
      input  add_sum, add_c, add_o
   );
endinterface

// File: rtl/calc_op_sequencer.sv
// Sequences the shared adder-subtractor: one-pass ADD/SUB,
// 16-pass shift-and-add MUL, result returned on a valid/ready channel.
module calc_op_sequencer #(
   parameter int WIDTH     = 16,
   parameter int RES_WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   calc_op_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      MUL,
      RESP
   } state_t;

   localparam logic [3:0] OP_ADD = 4'd2;
   localparam logic [3:0] OP_SUB = 4'd3;
   localparam logic [3:0] OP_MUL = 4'd4;
   localparam logic [3:0] LAST   = 4'(WIDTH - 1);

   state_t           state;
   logic [3:0]       op_r;
   logic [WIDTH-1:0] p_r;
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [3:0]       cnt;

   logic             is_as;
   logic             is_mul;
   logic [WIDTH-1:0] sum_w;
   logic [WIDTH-1:0] hi_nx;
   logic [WIDTH-1:0] lo_nx;
   logic             sum_unused;

   assign is_as  = (bus.cmd_op == OP_ADD) ||
                   (bus.cmd_op == OP_SUB);
   assign is_mul = (bus.cmd_op == OP_MUL);

   assign sum_w      = bus.add_sum[WIDTH-1:0];
   assign sum_unused = ^bus.add_sum[RES_WIDTH-1:WIDTH];

   // One shift-and-add step: {carry, sum, lo} shifted right by one.
   assign hi_nx = {bus.add_c, sum_w[WIDTH-1:1]};
   assign lo_nx = {sum_w[0], lo[WIDTH-1:1]};

   always_comb begin
      bus.add_p   = '0;
      bus.add_q   = '0;
      bus.add_cmd = '0;
      unique case (state)
         EXEC: begin
            bus.add_p   = p_r;
            bus.add_q   = q_r;
            bus.add_cmd = op_r;
         end
         MUL: begin
            bus.add_p   = hi;
            bus.add_q   = lo[0] ? p_r : '0;
            bus.add_cmd = OP_ADD;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         bus.cmd_ready    <= 1'b1;
         bus.rsp_valid    <= 1'b0;
         bus.rsp_result   <= '0;
         bus.rsp_carry    <= 1'b0;
         bus.rsp_overflow <= 1'b0;
         bus.rsp_error    <= 1'b0;
         op_r             <= '0;
         p_r              <= '0;
         q_r              <= '0;
         hi               <= '0;
         lo               <= '0;
         cnt              <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  op_r          <= bus.cmd_op;
                  p_r           <= bus.cmd_p;
                  q_r           <= bus.cmd_q;
                  bus.cmd_ready <= 1'b0;
                  unique case (1'b1)
                     is_as: begin
                        state <= EXEC;
                     end
                     is_mul: begin
                        state <= MUL;
                        hi    <= '0;
                        lo    <= bus.cmd_q;
                        cnt   <= '0;
                     end
                     default: begin
                        state            <= RESP;
                        bus.rsp_valid    <= 1'b1;
                        bus.rsp_result   <= '0;
                        bus.rsp_carry    <= 1'b0;
                        bus.rsp_overflow <= 1'b0;
                        bus.rsp_error    <= 1'b1;
                     end
                  endcase
               end
            end
            EXEC: begin
               state            <= RESP;
               bus.rsp_valid    <= 1'b1;
               bus.rsp_result   <= {{(RES_WIDTH-WIDTH){1'b0}}, sum_w};
               bus.rsp_carry    <= bus.add_c;
               bus.rsp_overflow <= bus.add_o;
               bus.rsp_error    <= 1'b0;
            end
            MUL: begin
               hi  <= hi_nx;
               lo  <= lo_nx;
               cnt <= cnt + 4'd1;
               if (cnt == LAST) begin
                  state            <= RESP;
                  bus.rsp_valid    <= 1'b1;
                  bus.rsp_result   <= {hi_nx, lo_nx};
                  bus.rsp_carry    <= 1'b0;
                  bus.rsp_overflow <= |hi_nx;
                  bus.rsp_error    <= 1'b0;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  state         <= IDLE;
                  bus.rsp_valid <= 1'b0;
                  bus.cmd_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Bench for calc_op_sequencer: behavioural adder, vector table,
// random vectors, back-pressure and mid-MUL reset sequences.
module tb_calc_op_sequencer;

   logic clk = 1'b0;
   logic rst_n;

   calc_op_sequencer_if bus ();

   calc_op_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] p;
      logic [15:0] q;
      int          hold;
      logic [31:0] res;
      logic        c;
      logic        o;
      logic        e;
      int          lat;
   } vec_t;

   int   checks   = 0;
   int   failures = 0;
   vec_t sb[$];
   vec_t tbl[12];

   // External add_sub unit; upper sum bits carry junk on purpose.
   logic [16:0] am_s;
   logic        am_sub;
   always_comb begin
      am_sub = (bus.add_cmd == 4'd3);
      if (am_sub)
         am_s = {1'b0, bus.add_p} - {1'b0, bus.add_q};
      else
         am_s = {1'b0, bus.add_p} + {1'b0, bus.add_q};
      bus.add_sum = {16'hA5A5, am_s[15:0]};
      bus.add_c   = am_s[16];
      if (am_sub)
         bus.add_o = (bus.add_p[15] != bus.add_q[15]) &&
                     (am_s[15] != bus.add_p[15]);
      else
         bus.add_o = (bus.add_p[15] == bus.add_q[15]) &&
                     (am_s[15] != bus.add_p[15]);
   end

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t ref_vec(input logic [3:0] op,
                                    input logic [15:0] p,
                                    input logic [15:0] q);
      vec_t        v;
      logic [16:0] s;
      logic [31:0] m;
      v.op = op; v.p = p; v.q = q; v.hold = 0;
      v.c = 1'b0; v.o = 1'b0; v.e = 1'b0;
      if (op == 4'd2) begin
         s = {1'b0, p} + {1'b0, q};
         v.res = {16'h0, s[15:0]};
         v.c = s[16];
         v.o = (p[15] == q[15]) && (s[15] != p[15]);
         v.lat = 2;
      end else if (op == 4'd3) begin
         s = {1'b0, p} - {1'b0, q};
         v.res = {16'h0, s[15:0]};
         v.c = s[16];
         v.o = (p[15] != q[15]) && (s[15] != p[15]);
         v.lat = 2;
      end else begin
         m = 32'(p) * 32'(q);
         v.res = m;
         v.o = (m[31:16] != 16'h0);
         v.lat = 17;
      end
      return v;
   endfunction

   function automatic vec_t mk(input logic [3:0] op,
                               input logic [15:0] p,
                               input logic [15:0] q,
                               input int hold,
                               input logic [31:0] res,
                               input logic c, input logic o,
                               input logic e, input int lat);
      vec_t v;
      v.op = op; v.p = p; v.q = q; v.hold = hold;
      v.res = res; v.c = c; v.o = o; v.e = e; v.lat = lat;
      return v;
   endfunction

   task automatic send(input logic [3:0] op,
                       input logic [15:0] p,
                       input logic [15:0] q,
                       output bit acc);
      logic rdy;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_p     = p;
      bus.cmd_q     = q;
      acc = 1'b0;
      for (int n = 0; n < 20 && !acc; n++) begin
         rdy = bus.cmd_ready;
         @(posedge clk);
         acc = rdy;
      end
      #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic run(input vec_t v, input string tag);
      vec_t        e;
      bit          acc;
      int          lat;
      int          subc;
      int          drv;
      logic [35:0] snap;
      send(v.op, v.p, v.q, acc);
      chk({tag, ".accept"}, 64'(acc), 64'd1);
      if (!acc) return;
      sb.push_back(v);
      lat = 1; subc = 0; drv = 0;
      while (1) begin
         if (bus.add_cmd == 4'd3) subc++;
         if ((bus.add_p | bus.add_q | 16'(bus.add_cmd)) != 16'h0)
            drv++;
         if (bus.rsp_valid || lat >= 40) break;
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, ".latency"}, 64'(lat), 64'(v.lat));
      chk({tag, ".sub_cycles"}, 64'(subc),
          64'(v.op == 4'd3 ? 1 : 0));
      if (v.e) chk({tag, ".adder_idle"}, 64'(drv), 64'd0);
      snap = {bus.rsp_valid, bus.rsp_result, bus.rsp_carry,
              bus.rsp_overflow, bus.rsp_error};
      for (int h = 0; h < v.hold; h++) begin
         bus.cmd_valid = 1'b1;
         bus.cmd_op    = 4'd2;
         bus.cmd_p     = 16'h0101;
         bus.cmd_q     = 16'h0202;
         @(posedge clk); #1;
         chk({tag, ".hold_stable"},
             {bus.rsp_valid, bus.rsp_result, bus.rsp_carry,
              bus.rsp_overflow, bus.rsp_error}, snap);
         chk({tag, ".hold_busy"}, 64'(bus.cmd_ready), 64'd0);
      end
      bus.cmd_valid = 1'b0;
      snap = {bus.rsp_valid, bus.rsp_result, bus.rsp_carry,
              bus.rsp_overflow, bus.rsp_error};
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      e = sb.pop_front();
      chk({tag, ".result"}, 64'(snap[34:3]), 64'(e.res));
      chk({tag, ".flags"}, 64'(snap[2:0]), 64'({e.c, e.o, e.e}));
      chk({tag, ".after_hs"},
          64'({bus.rsp_valid, bus.cmd_ready}), 64'b01);
   endtask

   initial begin
      bit          acc;
      vec_t        rv;
      logic [3:0]  rop;
      rst_n          = 1'b0;
      bus.cmd_valid  = 1'b0;
      bus.cmd_op     = 4'd0;
      bus.cmd_p      = 16'h0;
      bus.cmd_q      = 16'h0;
      bus.rsp_ready  = 1'b0;

      tbl[0]  = mk(4'd2, 16'h7FFF, 16'h0001, 0, 32'h00008000, 0, 1, 0, 2);
      tbl[1]  = mk(4'd3, 16'h0005, 16'h0007, 0, 32'h0000FFFE, 1, 0, 0, 2);
      tbl[2]  = mk(4'd4, 16'hFFFF, 16'hFFFF, 0, 32'hFFFE0001, 0, 1, 0, 17);
      tbl[3]  = mk(4'd4, 16'h0003, 16'h0004, 0, 32'h0000000C, 0, 0, 0, 17);
      tbl[4]  = mk(4'hF, 16'h1234, 16'h5678, 0, 32'h0, 0, 0, 1, 1);
      tbl[5]  = mk(4'd2, 16'hFFFF, 16'h0001, 5, 32'h00000000, 1, 0, 0, 2);
      tbl[6]  = mk(4'd3, 16'h8000, 16'h0001, 0, 32'h00007FFF, 0, 1, 0, 2);
      tbl[7]  = mk(4'd4, 16'h0000, 16'h1234, 0, 32'h00000000, 0, 0, 0, 17);
      tbl[8]  = mk(4'd4, 16'h1234, 16'h0010, 0, 32'h00012340, 0, 1, 0, 17);
      tbl[9]  = mk(4'd0, 16'hFFFF, 16'hFFFF, 0, 32'h0, 0, 0, 1, 1);
      tbl[10] = mk(4'd5, 16'h0003, 16'h0004, 3, 32'h0, 0, 0, 1, 1);
      tbl[11] = mk(4'd3, 16'h0007, 16'h0007, 0, 32'h00000000, 0, 0, 0, 2);

      repeat (3) @(posedge clk);
      #1;
      chk("reset.ready_valid",
          64'({bus.cmd_ready, bus.rsp_valid}), 64'b10);
      chk("reset.rsp",
          {bus.rsp_result, bus.rsp_carry, bus.rsp_overflow,
           bus.rsp_error}, 64'h0);
      chk("reset.adder",
          64'({bus.add_p, bus.add_q, bus.add_cmd}), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++)
         run(tbl[i], $sformatf("vec%0d", i));

      for (int i = 0; i < 6; i++) begin
         rop = 4'(2 + (i % 3));
         rv  = ref_vec(rop, 16'($urandom), 16'($urandom));
         run(rv, $sformatf("rnd%0d", i));
      end

      // Reset while the multiplier is part way through.
      send(4'd4, 16'h1234, 16'h5678, acc);
      chk("rst_mid.accept", 64'(acc), 64'd1);
      repeat (7) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid.ready_valid",
          64'({bus.cmd_ready, bus.rsp_valid}), 64'b10);
      chk("rst_mid.adder",
          64'({bus.add_p, bus.add_q, bus.add_cmd}), 64'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk); #1;
         if (bus.rsp_valid) break;
      end
      chk("rst_mid.no_rsp", 64'(bus.rsp_valid), 64'd0);
      run(mk(4'd2, 16'h0001, 16'h0001, 0, 32'h00000002, 0, 0, 0, 2),
          "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
